nn_cfg_loader: RTL

Sequencer that fills the 4-entry NN layer configuration register file from a valid/ready word stream, then starts the NN datapath and waits for it to finish. It owns the config file's write port (data, address, write enable) and the datapath start/done handshake. It sits between the host/DMA config stream and the config register file plus NN engine, and runs one layer per configuration burst.

---
 rtl/nn_cfg_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nn_cfg_loader.sv
// nn_cfg_loader: streams NUM_CFG config words into the layer config file, then pulses start
// to the NN datapath and waits for done. Optional BUSY watchdog: define NN_CFG_TIMEOUT_EN.
module nn_cfg_loader #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned NUM_CFG     = 4,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_cfg_data,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   output logic [DATA_W-1:0] o_cfg,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_wr_en,
   output logic              o_start,
   input  logic              i_done,
   output logic              o_busy,
   output logic [7:0]        o_layer_cnt,
   output logic              o_timeout
);

   localparam logic [1:0] StLoad  = 2'd0;
   localparam logic [1:0] StFlush = 2'd1;
   localparam logic [1:0] StStart = 2'd2;
   localparam logic [1:0] StBusy  = 2'd3;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_CFG - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] cfg_q, cfg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic              start_q, start_d;
   logic [7:0]        layer_cnt_q, layer_cnt_d;
   logic              expire;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cfg_d       = cfg_q;
      addr_d      = addr_q;
      wr_en_d     = 1'b0;
      start_d     = 1'b0;
      layer_cnt_d = layer_cnt_q;
      unique case (state_q)
         StLoad: begin
            if (i_cfg_valid) begin
               cfg_d   = i_cfg_data;
               addr_d  = idx_q;
               wr_en_d = 1'b1;
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = StFlush;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StFlush: begin
            // last write strobe is on the bus now; start follows right behind it
            state_d = StStart;
            start_d = 1'b1;
         end
         StStart: begin
            state_d = StBusy;
         end
         StBusy: begin
            if (i_done) begin
               state_d     = StLoad;
               layer_cnt_d = layer_cnt_q + 8'd1;
            end else if (expire) begin
               state_d = StLoad;
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StLoad;
         idx_q       <= '0;
         cfg_q       <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         start_q     <= 1'b0;
         layer_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cfg_q       <= cfg_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         start_q     <= start_d;
         layer_cnt_q <= layer_cnt_d;
      end
   end

`ifdef NN_CFG_TIMEOUT_EN
   localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYC - 1);

   logic [15:0] wdog_q, wdog_d;
   logic        timeout_q;

   // done on the expiry cycle takes priority over the timeout
   assign expire = (state_q == StBusy) && !i_done && (wdog_q == WdogLast);

   always_comb begin
      wdog_d = wdog_q;
      if (state_q == StStart) begin
         wdog_d = '0;
      end else if ((state_q == StBusy) && !i_done) begin
         wdog_d = wdog_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= expire;
      end
   end

   assign o_timeout = timeout_q;
`else
   logic unused_timeout_cyc;

   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign expire             = 1'b0;
   assign o_timeout          = 1'b0;
`endif

   assign o_cfg_ready = (state_q == StLoad);
   assign o_busy      = (state_q != StLoad);
   assign o_cfg       = cfg_q;
   assign o_addr      = addr_q;
   assign o_wr_en     = wr_en_q;
   assign o_start     = start_q;
   assign o_layer_cnt = layer_cnt_q;

endmodule
